// File: rtl/param_bus_datapath.sv
// Parametrised single-bus CPU datapath: GPR bank, HI/LO, Y, Z, PC, MAR, MDR and
// constant source on one shared bus, with contention detection and a timed memory read into MDR.
module param_bus_datapath #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_GPR     = 16,
    parameter int unsigned R0_ZERO     = 0,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic [NUM_GPR-1:0]        gpr_in,
    input  logic [NUM_GPR-1:0]        gpr_out,
    input  logic                      HIin,
    input  logic                      LOin,
    input  logic                      PCin,
    input  logic                      Yin,
    input  logic                      MARin,
    input  logic                      MDRin,
    input  logic                      HIout,
    input  logic                      LOout,
    input  logic                      PCout,
    input  logic                      Zhighout,
    input  logic                      Zlowout,
    input  logic                      MDRout,
    input  logic                      Cout,
    input  logic                      IncPC,
    input  logic                      Zin,
    input  logic                      Read,
    input  logic [2*DATA_WIDTH-1:0]   alu_result,
    input  logic [DATA_WIDTH-1:0]     csign_value,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     bus_value,
    output logic [DATA_WIDTH-1:0]     y_value,
    output logic [DATA_WIDTH-1:0]     mar_value,
    output logic [DATA_WIDTH-1:0]     pc_value,
    output logic                      mem_read_req,
    output logic                      mdr_busy,
    output logic                      bus_conflict,
    output logic                      mem_timeout_err
);

    localparam int unsigned W       = DATA_WIDTH;
    localparam int unsigned NUM_FIX = 7;
    localparam int unsigned CNT_W   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    logic [W-1:0]     gpr_q [NUM_GPR];
    logic [W-1:0]     gpr_d [NUM_GPR];
    logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, y_q, y_d, mar_q, mar_d;
    logic [W-1:0]     zh_q, zh_d, zl_q, zl_d, pc_q, pc_d, mdr_q, mdr_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d, busy_q, busy_d, err_q, err_d;

    logic [W-1:0]       bus_c;
    logic               conflict_c;
    logic [W-1:0]       fix_val [NUM_FIX];
    logic [NUM_FIX-1:0] fix_sel;

    // Non-GPR sources, index 0 is highest priority
    always_comb begin
        fix_val[0] = hi_q;
        fix_val[1] = lo_q;
        fix_val[2] = zh_q;
        fix_val[3] = zl_q;
        fix_val[4] = pc_q;
        fix_val[5] = mdr_q;
        fix_val[6] = csign_value;
        fix_sel    = {Cout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout};
    end

    // Priority bus mux; a second asserted driver flags contention
    always_comb begin
        logic found;
        found      = 1'b0;
        bus_c      = '0;
        conflict_c = 1'b0;
        for (int i = 0; i < int'(NUM_GPR); i++) begin
            if (gpr_out[i]) begin
                if (found) begin
                    conflict_c = 1'b1;
                end else begin
                    bus_c = gpr_q[i];
                    found = 1'b1;
                end
            end
        end
        for (int j = 0; j < int'(NUM_FIX); j++) begin
            if (fix_sel[j]) begin
                if (found) begin
                    conflict_c = 1'b1;
                end else begin
                    bus_c = fix_val[j];
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gpr_d   = gpr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        y_d     = y_q;
        mar_d   = mar_q;
        zh_d    = zh_q;
        zl_d    = zl_q;
        pc_d    = pc_q;
        mdr_d   = mdr_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        // R0 is never written when hardwired to zero; reset keeps it at 0
        for (int i = 0; i < int'(NUM_GPR); i++) begin
            if (gpr_in[i] && !(R0_ZERO != 0 && i == 0)) begin
                gpr_d[i] = bus_c;
            end
        end
        if (HIin)  hi_d  = bus_c;
        if (LOin)  lo_d  = bus_c;
        if (Yin)   y_d   = bus_c;
        if (MARin) mar_d = bus_c;
        if (Zin) begin
            zh_d = alu_result[2*W-1:W];
            zl_d = alu_result[W-1:0];
        end
        if (PCin) begin
            pc_d = bus_c;
        end else if (IncPC) begin
            pc_d = pc_q + W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (MDRin) begin
                    if (Read) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        mdr_d = bus_c;
                    end
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    mdr_d   = mem_data_in;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d  = (state_d == S_WAIT);
        busy_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < int'(NUM_GPR); i++) begin
                gpr_q[i] <= '0;
            end
            hi_q    <= '0;
            lo_q    <= '0;
            y_q     <= '0;
            mar_q   <= '0;
            zh_q    <= '0;
            zl_q    <= '0;
            pc_q    <= '0;
            mdr_q   <= '0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_GPR); i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            y_q     <= y_d;
            mar_q   <= mar_d;
            zh_q    <= zh_d;
            zl_q    <= zl_d;
            pc_q    <= pc_d;
            mdr_q   <= mdr_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus_value       = bus_c;
    assign bus_conflict    = conflict_c;
    assign y_value         = y_q;
    assign mar_value       = mar_q;
    assign pc_value        = pc_q;
    assign mem_read_req    = req_q;
    assign mdr_busy        = busy_q;
    assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Scoreboard bench for param_bus_datapath: a driver pushes expectations from a
// register-level reference model, a negedge monitor pops and compares.
module tb_param_bus_datapath;

    localparam int unsigned W   = 32;
    localparam int unsigned N   = 16;
    localparam int unsigned TO  = 15;
    localparam bit          R0Z = 1'b1;

    logic             clock = 1'b0;
    logic             clear;
    logic [N-1:0]     gpr_in, gpr_out;
    logic             HIin, LOin, PCin, Yin, MARin, MDRin;
    logic             HIout, LOout, PCout, Zhighout, Zlowout, MDRout, Cout;
    logic             IncPC, Zin, Read, mem_ready;
    logic [2*W-1:0]   alu_result;
    logic [W-1:0]     csign_value, mem_data_in;
    logic [W-1:0]     bus_value, y_value, mar_value, pc_value;
    logic             mem_read_req, mdr_busy, bus_conflict, mem_timeout_err;

    always #5 clock = ~clock;

    param_bus_datapath #(
        .DATA_WIDTH (W),
        .NUM_GPR    (N),
        .R0_ZERO    (1),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clock          (clock),
        .clear          (clear),
        .gpr_in         (gpr_in),
        .gpr_out        (gpr_out),
        .HIin           (HIin),
        .LOin           (LOin),
        .PCin           (PCin),
        .Yin            (Yin),
        .MARin          (MARin),
        .MDRin          (MDRin),
        .HIout          (HIout),
        .LOout          (LOout),
        .PCout          (PCout),
        .Zhighout       (Zhighout),
        .Zlowout        (Zlowout),
        .MDRout         (MDRout),
        .Cout           (Cout),
        .IncPC          (IncPC),
        .Zin            (Zin),
        .Read           (Read),
        .alu_result     (alu_result),
        .csign_value    (csign_value),
        .mem_data_in    (mem_data_in),
        .mem_ready      (mem_ready),
        .bus_value      (bus_value),
        .y_value        (y_value),
        .mar_value      (mar_value),
        .pc_value       (pc_value),
        .mem_read_req   (mem_read_req),
        .mdr_busy       (mdr_busy),
        .bus_conflict   (bus_conflict),
        .mem_timeout_err(mem_timeout_err)
    );

    typedef struct packed {
        logic           clear;
        logic [N-1:0]   gpr_in;
        logic [N-1:0]   gpr_out;
        logic           hi_in, lo_in, pc_in, y_in, mar_in, mdr_in;
        logic           hi_out, lo_out, pc_out, zh_out, zl_out, mdr_out, c_out;
        logic           inc_pc, z_in, read, mem_ready;
        logic [2*W-1:0] alu;
        logic [W-1:0]   csign;
        logic [W-1:0]   mem_data;
    } stim_t;

    typedef struct {
        logic [W-1:0] bus;
        logic         conflict;
        logic [W-1:0] y, mar, pc;
        logic         req, busy, err;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc_n = 0;

    // Reference model: architectural register contents plus an outstanding-read record
    logic [W-1:0] m_gpr [N];
    logic [W-1:0] m_hi, m_lo, m_y, m_mar, m_zh, m_zl, m_pc, m_mdr;
    bit           m_wait, m_err;
    int           m_waited;

    function automatic void model_reset();
        for (int i = 0; i < int'(N); i++) m_gpr[i] = '0;
        m_hi = '0; m_lo = '0; m_y = '0; m_mar = '0;
        m_zh = '0; m_zl = '0; m_pc = '0; m_mdr = '0;
        m_wait = 0; m_err = 0; m_waited = 0;
    endfunction

    // Collect every driver in priority order; the first one wins
    function automatic void model_bus(input stim_t s, output logic [W-1:0] v, output logic c);
        logic [W-1:0] drv[$];
        for (int i = 0; i < int'(N); i++)
            if (s.gpr_out[i]) drv.push_back((i == 0 && R0Z) ? '0 : m_gpr[i]);
        if (s.hi_out)  drv.push_back(m_hi);
        if (s.lo_out)  drv.push_back(m_lo);
        if (s.zh_out)  drv.push_back(m_zh);
        if (s.zl_out)  drv.push_back(m_zl);
        if (s.pc_out)  drv.push_back(m_pc);
        if (s.mdr_out) drv.push_back(m_mdr);
        if (s.c_out)   drv.push_back(s.csign);
        v = (drv.size() > 0) ? drv[0] : '0;
        c = (drv.size() >= 2);
    endfunction

    function automatic void model_step(input stim_t s);
        logic [W-1:0] b;
        logic         c;
        model_bus(s, b, c);
        if (s.clear) begin
            model_reset();
            return;
        end
        for (int i = 0; i < int'(N); i++)
            if (s.gpr_in[i] && !(i == 0 && R0Z)) m_gpr[i] = b;
        if (s.hi_in)  m_hi  = b;
        if (s.lo_in)  m_lo  = b;
        if (s.y_in)   m_y   = b;
        if (s.mar_in) m_mar = b;
        if (s.z_in) begin
            m_zh = s.alu[2*W-1:W];
            m_zl = s.alu[W-1:0];
        end
        if (s.pc_in)       m_pc = b;
        else if (s.inc_pc) m_pc = m_pc + 32'd1;
        if (!m_wait) begin
            if (s.mdr_in && s.read) begin
                m_wait   = 1;
                m_waited = 0;
            end else if (s.mdr_in) begin
                m_mdr = b;
            end
        end else if (s.mem_ready) begin
            m_mdr  = s.mem_data;
            m_wait = 0;
        end else if (m_waited == int'(TO) - 1) begin
            m_err  = 1;
            m_wait = 0;
        end else begin
            m_waited++;
        end
    endfunction

    task automatic apply(input stim_t s);
        clear = s.clear; gpr_in = s.gpr_in; gpr_out = s.gpr_out;
        HIin = s.hi_in; LOin = s.lo_in; PCin = s.pc_in; Yin = s.y_in;
        MARin = s.mar_in; MDRin = s.mdr_in;
        HIout = s.hi_out; LOout = s.lo_out; PCout = s.pc_out;
        Zhighout = s.zh_out; Zlowout = s.zl_out; MDRout = s.mdr_out; Cout = s.c_out;
        IncPC = s.inc_pc; Zin = s.z_in; Read = s.read; mem_ready = s.mem_ready;
        alu_result = s.alu; csign_value = s.csign; mem_data_in = s.mem_data;
    endtask

    // Drive one cycle: expectation reflects state before this cycle's edge
    task automatic cycle(input stim_t s);
        exp_t e;
        @(posedge clock);
        #1;
        apply(s);
        model_bus(s, e.bus, e.conflict);
        e.y = m_y; e.mar = m_mar; e.pc = m_pc;
        e.req = m_wait; e.busy = m_wait; e.err = m_err;
        e.cyc = cyc_n;
        sb.push_back(e);
        model_step(s);
        cyc_n++;
    endtask

    function automatic void chk(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp, input int cyc);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("bus_value",       bus_value,           e.bus,           e.cyc);
            chk("bus_conflict",    W'(bus_conflict),    W'(e.conflict),  e.cyc);
            chk("y_value",         y_value,             e.y,             e.cyc);
            chk("mar_value",       mar_value,           e.mar,           e.cyc);
            chk("pc_value",        pc_value,            e.pc,            e.cyc);
            chk("mem_read_req",    W'(mem_read_req),    W'(e.req),       e.cyc);
            chk("mdr_busy",        W'(mdr_busy),        W'(e.busy),      e.cyc);
            chk("mem_timeout_err", W'(mem_timeout_err), W'(e.err),       e.cyc);
        end
    end

    function automatic stim_t with_out(input stim_t s, input int k);
        stim_t r = s;
        if (k < int'(N)) r.gpr_out[k] = 1'b1;
        else case (k - int'(N))
            0: r.hi_out  = 1'b1;
            1: r.lo_out  = 1'b1;
            2: r.zh_out  = 1'b1;
            3: r.zl_out  = 1'b1;
            4: r.pc_out  = 1'b1;
            5: r.mdr_out = 1'b1;
            default: r.c_out = 1'b1;
        endcase
        return r;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = '0;
        int    n;
        s.clear = ($urandom_range(0, 99) == 0);
        n = $urandom_range(0, 9);
        if (n >= 3) s = with_out(s, $urandom_range(0, N + 6));
        if (n >= 8) s = with_out(s, $urandom_range(0, N + 6));
        if ($urandom_range(0, 1) == 1) s.gpr_in[$urandom_range(0, N - 1)] = 1'b1;
        if ($urandom_range(0, 7) == 0) s.gpr_in[$urandom_range(0, N - 1)] = 1'b1;
        s.hi_in     = ($urandom_range(0, 5) == 0);
        s.lo_in     = ($urandom_range(0, 5) == 0);
        s.pc_in     = ($urandom_range(0, 7) == 0);
        s.y_in      = ($urandom_range(0, 5) == 0);
        s.mar_in    = ($urandom_range(0, 5) == 0);
        s.mdr_in    = ($urandom_range(0, 4) == 0);
        s.read      = ($urandom_range(0, 1) == 1);
        s.inc_pc    = ($urandom_range(0, 5) == 0);
        s.z_in      = ($urandom_range(0, 5) == 0);
        s.mem_ready = ($urandom_range(0, 3) == 0);
        s.alu       = {$urandom(), $urandom()};
        s.csign     = $urandom();
        s.mem_data  = $urandom();
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        s = '0;
        s.clear = 1'b1;
        apply(s);
        @(posedge clock);
        model_reset();

        // Reset with no strobes
        cycle(s);
        s = '0; cycle(s); cycle(s);

        // Constant into R3, read back, then contention with PC
        s = '0; s.c_out = 1; s.csign = 32'h0000_00A5; s.gpr_in[3] = 1; cycle(s);
        s = '0; s.gpr_out[3] = 1; cycle(s);
        s.pc_out = 1; cycle(s);

        // PC wrap and PCin-over-IncPC
        s = '0; s.c_out = 1; s.csign = 32'hFFFF_FFFF; s.pc_in = 1; cycle(s);
        s = '0; s.inc_pc = 1; cycle(s);
        s = '0; s.c_out = 1; s.csign = 32'h0000_0010; s.pc_in = 1; s.inc_pc = 1; cycle(s);
        s = '0; s.pc_out = 1; cycle(s);

        // Wait-stated read answered on the third wait cycle
        s = '0; s.mdr_in = 1; s.read = 1; cycle(s);
        s = '0; s.mdr_in = 1; s.c_out = 1; s.csign = 32'h1111_1111; cycle(s);
        s = '0; s.mdr_out = 1; cycle(s);
        s = '0; s.mem_ready = 1; s.mem_data = 32'hDEAD_BEEF; cycle(s);
        s = '0; s.mdr_out = 1; cycle(s);

        // Read with no ready: timeout, MDR kept, later read still works
        s = '0; s.mdr_in = 1; s.read = 1; cycle(s);
        s = '0;
        for (int i = 0; i < int'(TO) + 2; i++) cycle(s);
        s = '0; s.mdr_out = 1; cycle(s);
        s = '0; s.mdr_in = 1; s.read = 1; cycle(s);
        s = '0; s.mem_ready = 1; s.mem_data = 32'h0BAD_F00D; cycle(s);
        s = '0; s.mdr_out = 1; cycle(s);
        s = '0; s.clear = 1; cycle(s);
        s = '0; cycle(s);

        // Hardwired R0 and Z halves
        s = '0; s.c_out = 1; s.csign = 32'h0000_1234; s.gpr_in[0] = 1; cycle(s);
        s = '0; s.gpr_out[0] = 1; cycle(s);
        s = '0; s.z_in = 1; s.alu = 64'h0000_0001_8000_0000; cycle(s);
        s = '0; s.zh_out = 1; cycle(s);
        s = '0; s.zl_out = 1; cycle(s);

        // Clear in the middle of a read
        s = '0; s.mdr_in = 1; s.read = 1; cycle(s);
        s = '0; cycle(s);
        s = '0; s.clear = 1; s.mem_ready = 1; s.mem_data = 32'h5555_5555; cycle(s);
        s = '0; s.mdr_out = 1; cycle(s);

        for (int i = 0; i < 3000; i++) cycle(rand_stim());

        @(negedge clock);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/param_bus_datapath.md
Name: param_bus_datapath

Overview:
- Parametrised successor to the single-bus CPU datapath: GPR bank, HI/LO, Y, 2W-bit Z, PC, MAR, MDR and C-constant source share one internal bus.
- Adds configurable width and register count, an optional hardwired-zero R0, and bus-contention detection.
- Adds a wait-stated memory read handshake into MDR with a timeout.
- Sits between the control unit (drives the *in/*out strobes) and the ALU/memory.

Parameters:
- DATA_WIDTH, 32, bus/register width W.
- NUM_GPR, 16, number of general registers (2..32).
- R0_ZERO, 0, when 1 R0 always reads 0 and ignores writes.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before abort (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- gpr_in  in  NUM_GPR  one-hot-intended GPR load strobes.
- gpr_out  in  NUM_GPR  GPR bus-drive strobes.
- HIin/LOin/PCin/Yin/MARin/MDRin  in  1 each  register load strobes.
- HIout/LOout/PCout/Zhighout/Zlowout/MDRout/Cout  in  1 each  bus-drive strobes.
- IncPC  in  1  increment PC.
- Zin  in  1  load Z from alu_result.
- Read  in  1  with MDRin, selects a memory read into MDR.
- alu_result  in  2*W  ALU output; upper half goes to Zhigh.
- csign_value  in  W  sign-extended constant driven by Cout.
- mem_data_in  in  W  memory read data.
- mem_ready  in  1  memory data valid.
- bus_value  out  W  current bus value (combinational).
- y_value, mar_value, pc_value  out  W  register contents.
- mem_read_req  out  1  read request to memory.
- mdr_busy  out  1  handshake in progress.
- bus_conflict  out  1  more than one bus driver this cycle (combinational).
- mem_timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset: synchronous on clear. All registers and the wait counter go to 0. FSM goes to IDLE. mem_read_req=0, mdr_busy=0, mem_timeout_err=0. clear overrides every strobe in that cycle.
- Bus: combinational.
  - Sources in priority order: GPR0..GPR(N-1), HI, LO, Zhigh, Zlow, PC, MDR, C.
  - bus_value is the highest-priority asserted source, or 0 if none is asserted.
  - bus_conflict=1 when two or more *out strobes are high.
- Loads: on the rising edge the register takes bus_value when its *in strobe is high.
  - Multiple simultaneous *in strobes are legal; all take the same value.
  - R0 with R0_ZERO=1: write ignored, drives 0.
- Z: on Zin, Zhigh<=alu_result[2W-1:W] and Zlow<=alu_result[W-1:0]. Not loadable from the bus.
- PC: PCin has priority over IncPC. IncPC alone gives PC<=PC+1 modulo 2^W, so all-ones wraps to 0.
- MDR direct load: MDRin && !Read in IDLE gives MDR<=bus_value with 1-edge latency.
- MDR read FSM, states IDLE and WAIT:
  - IDLE, MDRin && Read: go to WAIT, counter<=0. mem_read_req and mdr_busy go high from the next cycle.
  - WAIT, mem_ready=1: MDR<=mem_data_in, go to IDLE. req and busy drop after that edge. Minimum latency is 2 edges from the request edge.
  - WAIT, mem_ready=0: counter++. When the counter reaches MEM_TIMEOUT-1 without ready: mem_timeout_err<=1, MDR unchanged, go to IDLE.
  - While in WAIT: MDRin and Read are ignored. MDRout drives the old MDR. All other registers operate normally.
  - clear in WAIT aborts the read: req drops after that edge and MDR becomes 0.
- mem_timeout_err stays set until clear. Later reads still proceed normally.
- All outputs are registered except bus_value and bus_conflict.

Test Plan:
- Reset then no strobes -> bus_value=0, pc_value=0, mem_read_req=0, mem_timeout_err=0.
- Cout with csign_value=0x0000_00A5 and gpr_in[3]=1 for one edge; next cycle gpr_out[3]=1 -> bus_value=0x0000_00A5, bus_conflict=0. Add PCout high as well -> bus_value still 0xA5 (R3 priority), bus_conflict=1.
- PCin with bus=0xFFFF_FFFF, then IncPC -> pc_value=0x0000_0000. PCin with bus=0x10 plus IncPC together -> pc_value=0x10.
- MDRin+Read, mem_ready asserted 3 cycles later with mem_data_in=0xDEAD_BEEF -> mdr_busy high for 3 cycles, then MDRout gives bus=0xDEAD_BEEF and mem_read_req=0.
- MDRin+Read with mem_ready held 0 and MEM_TIMEOUT=15 -> mem_timeout_err=1 after 15 wait cycles, MDR unchanged, FSM back in IDLE. Clear -> flag 0.
- R0_ZERO=1: gpr_in[0] with bus=0x1234 then gpr_out[0] -> bus_value=0. Zin with alu_result=0x0000_0001_8000_0000 -> Zhighout gives 0x1, Zlowout gives 0x8000_0000.
